boot_copy_engine: RTL and testbench

- Parametrised successor to the fixed-size boot copier.
- Copies a length-prefixed program image from boot memory into instruction memory.
- Pipelines one read per cycle against a configurable read latency, and relocates the image using source and destination base addresses.
- Holds the core in boot mode until the copy completes, and reports done and error status; sits between the boot ROM/SRAM and the instruction memory write port.

---
 rtl/boot_copy_pkg.sv | 19 +
 rtl/boot_copy_engine_rd_pipe.sv | 51 +++++
 rtl/boot_copy_engine.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_boot_copy_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_copy_pkg.sv
// boot_copy_pkg: shared definitions for the boot copy engine.
//   state_t        : 3-bit FSM state encoding used by boot_copy_engine.
//   RD_LATENCY_MAX : largest supported boot memory read latency.
package boot_copy_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_RD   = 3'd1,
    HDR_WAIT = 3'd2,
    COPY     = 3'd3,
    DRAIN    = 3'd4,
    CHECK    = 3'd5,
    DONE     = 3'd6,
    ERROR    = 3'd7
  } state_t;

  localparam int RD_LATENCY_MAX = 4;

endpackage

// File: rtl/boot_copy_engine_rd_pipe.sv
// boot_rd_pipe: delay line that tracks in-flight boot memory reads.
//   Each stage carries a valid bit and the write offset of one read; an entry
//   pushed in the cycle its read strobe is high emerges DEPTH cycles later,
//   aligned with the read data.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid/in_off : read being issued this cycle and its offset
//   out_valid/out_off : read whose data is on the memory bus this cycle
//   busy            : any read still in flight
module boot_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int OFF_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [OFF_W-1:0] in_off,
  output logic             out_valid,
  output logic [OFF_W-1:0] out_off,
  output logic             busy
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [OFF_W-1:0] off_q [DEPTH];
  logic [OFF_W-1:0] off_d [DEPTH];

  always_comb begin
    valid_d[0] = in_valid;
    off_d[0]   = in_off;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      off_d[i]   = off_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // NOTE: offsets are qualified by valid, so they carry no reset; only the
  // valid bits must come up cleared.
  always_ff @(posedge clk) begin
    off_q <= off_d;
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_off   = off_q[DEPTH-1];
  assign busy      = |valid_q;

endmodule

// File: rtl/boot_copy_engine.sv
// boot_copy_engine: copies a length-prefixed image from boot memory into
// instruction memory, one read per cycle, holding the core in boot mode
// until the copy completes.
//   Image layout at SRC_BASE: header word (length L in low ADDR_WIDTH bits),
//   then L payload words; payload word i is written to DST_BASE+i.
// Optional feature: define BOOT_COPY_CHECKSUM_EN to read a trailer word after
//   the payload and compare it with the modular sum of the payload.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   boot_start                          : start/restart pulse (IDLE/DONE/ERROR)
//   boot_mem_rd_en/addr, boot_mem_rd_data : boot memory read port
//   inst_mem_wr_en/addr/data            : instruction memory write port
//   boot_mode, boot_done, boot_err      : status levels
//   words_copied                        : writes issued during this boot
// RD_LATENCY must lie in 1..RD_LATENCY_MAX.
module boot_copy_engine
  import boot_copy_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int RD_LATENCY = 1,
  parameter int SRC_BASE   = 0,
  parameter int DST_BASE   = 0,
  parameter int MAX_WORDS  = 'h400,
  parameter int AUTO_START = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  boot_start,
  output logic                  boot_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] boot_mem_addr,
  input  logic [DATA_WIDTH-1:0] boot_mem_rd_data,
  output logic                  inst_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] inst_mem_addr,
  output logic [DATA_WIDTH-1:0] inst_mem_wr_data,
  output logic                  boot_mode,
  output logic                  boot_done,
  output logic                  boot_err,
  output logic [ADDR_WIDTH-1:0] words_copied
);

  localparam int WAIT_W = $clog2(RD_LATENCY_MAX);
  localparam int AWP1   = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] SRC   = ADDR_WIDTH'(SRC_BASE);
  localparam logic [ADDR_WIDTH-1:0] DST   = ADDR_WIDTH'(DST_BASE);
  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);
  localparam logic [AWP1-1:0]       MAX_L = AWP1'(MAX_WORDS);

  state_t                  state_q, state_d;
  logic                    first_q, first_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    rd_pay_q, rd_pay_d;
  logic [ADDR_WIDTH-1:0]   rd_off_q, rd_off_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0]   words_q, words_d;
  logic                    mode_q, mode_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    pipe_vld, pipe_busy, is_trailer;
  logic [ADDR_WIDTH-1:0]   pipe_off;
  logic [ADDR_WIDTH-1:0]   hdr_len;

`ifdef BOOT_COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
  logic [DATA_WIDTH-1:0]   trailer_q, trailer_d;
  // The trailer travels down the pipe tagged with offset L, past every payload offset.
  assign is_trailer = (pipe_off == len_q);
`else
  assign is_trailer = 1'b0;
`endif

  assign hdr_len = boot_mem_rd_data[ADDR_WIDTH-1:0];

  boot_rd_pipe #(
    .DEPTH (RD_LATENCY),
    .OFF_W (ADDR_WIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_pay_q),
    .in_off    (rd_off_q),
    .out_valid (pipe_vld),
    .out_off   (pipe_off),
    .busy      (pipe_busy)
  );

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    first_d   = 1'b0;
    wait_d    = wait_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_pay_d  = 1'b0;
    rd_off_d  = rd_off_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    words_d   = words_q;
    mode_d    = mode_q;
    done_d    = done_q;
    err_d     = err_q;
`ifdef BOOT_COPY_CHECKSUM_EN
    sum_d     = sum_q;
    trailer_d = trailer_q;
`endif

    // Write path: data arriving now is registered onto the write port.
    if (pipe_vld) begin
      if (is_trailer) begin
`ifdef BOOT_COPY_CHECKSUM_EN
        trailer_d = boot_mem_rd_data;
`endif
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = DST + pipe_off;
        wr_data_d = boot_mem_rd_data;
        words_d   = words_q + ONE;
`ifdef BOOT_COPY_CHECKSUM_EN
        sum_d     = sum_q + boot_mem_rd_data;
`endif
      end
    end

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (boot_start || (state_q == IDLE && AUTO_START != 0 && first_q)) begin
          state_d   = HDR_RD;
          rd_en_d   = 1'b1;
          rd_addr_d = SRC;
          idx_d     = '0;
          words_d   = '0;
          mode_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
`ifdef BOOT_COPY_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      HDR_RD: begin
        state_d = HDR_WAIT;
        wait_d  = '0;
      end
      HDR_WAIT: begin
        if (wait_q == WAIT_W'(RD_LATENCY - 1)) begin
          len_d = hdr_len;
          if (hdr_len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            mode_d  = 1'b0;
          end else if ({1'b0, hdr_len} > MAX_L) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            state_d   = COPY;
            rd_en_d   = 1'b1;
            rd_addr_d = SRC + ONE;
            rd_pay_d  = 1'b1;
            rd_off_d  = '0;
            idx_d     = ONE;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      COPY: begin
        // idx_q is the offset of the next read; the current cycle already
        // shows read idx_q-1 on the port.
        if (idx_q != len_q) begin
          rd_en_d   = 1'b1;
          rd_addr_d = SRC + ONE + idx_q;
          rd_pay_d  = 1'b1;
          rd_off_d  = idx_q;
          idx_d     = idx_q + ONE;
        end else begin
          state_d = DRAIN;
`ifdef BOOT_COPY_CHECKSUM_EN
          rd_en_d   = 1'b1;
          rd_addr_d = SRC + ONE + len_q;
          rd_pay_d  = 1'b1;
          rd_off_d  = len_q;
`endif
        end
      end
      DRAIN: begin
        // rd_pay_q covers the read on the port that has not entered the pipe yet.
        if (!pipe_busy && !rd_pay_q) begin
`ifdef BOOT_COPY_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
          done_d  = 1'b1;
          mode_d  = 1'b0;
`endif
        end
      end
`ifdef BOOT_COPY_CHECKSUM_EN
      CHECK: begin
        if (sum_q == trailer_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          mode_d  = 1'b0;
        end else begin
          state_d = ERROR;
          err_d   = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= IDLE;
      first_q   <= 1'b1;
      wait_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_pay_q  <= 1'b0;
      rd_off_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      words_q   <= '0;
      mode_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef BOOT_COPY_CHECKSUM_EN
      sum_q     <= '0;
      trailer_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      wait_q    <= wait_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_pay_q  <= rd_pay_d;
      rd_off_q  <= rd_off_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      words_q   <= words_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef BOOT_COPY_CHECKSUM_EN
      sum_q     <= sum_d;
      trailer_q <= trailer_d;
`endif
    end
  end

  assign boot_mem_rd_en   = rd_en_q;
  assign boot_mem_addr    = rd_addr_q;
  assign inst_mem_wr_en   = wr_en_q;
  assign inst_mem_addr    = wr_addr_q;
  assign inst_mem_wr_data = wr_data_q;
  assign boot_mode        = mode_q;
  assign boot_done        = done_q;
  assign boot_err         = err_q;
  assign words_copied     = words_q;

endmodule

// File: tb/tb_boot_copy_engine.sv
// tb_boot_copy_engine: two engine instances (A: RD_LATENCY=3, relocated,
// auto start; B: RD_LATENCY=1, manual start) against behavioural boot memory
// models and an image-level reference model of the expected copy.
module tb_boot_copy_engine;

  localparam int AW   = 20;
  localparam int DW   = 32;
  localparam int MAXW = 16;
  localparam logic [DW-1:0] POISON = 32'hDEAD_BEEF;
`ifdef BOOT_COPY_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  function automatic int lat_of(input int k); return (k == 0) ? 3 : 1; endfunction
  function automatic int src_of(input int k); return (k == 0) ? 'h20 : 0; endfunction
  function automatic int dst_of(input int k); return (k == 0) ? 'h100 : 0; endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n_s      [2];
  logic          boot_start_s [2];
  logic          rd_en_s      [2];
  logic [AW-1:0] rd_addr_s    [2];
  logic [DW-1:0] rd_data_s    [2];
  logic          wr_en_s      [2];
  logic [AW-1:0] wr_addr_s    [2];
  logic [DW-1:0] wr_data_s    [2];
  logic          mode_s       [2];
  logic          done_s       [2];
  logic          err_s        [2];
  logic [AW-1:0] words_s      [2];

  boot_copy_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3), .SRC_BASE('h20),
    .DST_BASE('h100), .MAX_WORDS(MAXW), .AUTO_START(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n_s[0]), .boot_start(boot_start_s[0]),
    .boot_mem_rd_en(rd_en_s[0]), .boot_mem_addr(rd_addr_s[0]), .boot_mem_rd_data(rd_data_s[0]),
    .inst_mem_wr_en(wr_en_s[0]), .inst_mem_addr(wr_addr_s[0]), .inst_mem_wr_data(wr_data_s[0]),
    .boot_mode(mode_s[0]), .boot_done(done_s[0]), .boot_err(err_s[0]), .words_copied(words_s[0])
  );

  boot_copy_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .SRC_BASE(0),
    .DST_BASE(0), .MAX_WORDS(MAXW), .AUTO_START(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n_s[1]), .boot_start(boot_start_s[1]),
    .boot_mem_rd_en(rd_en_s[1]), .boot_mem_addr(rd_addr_s[1]), .boot_mem_rd_data(rd_data_s[1]),
    .inst_mem_wr_en(wr_en_s[1]), .inst_mem_addr(wr_addr_s[1]), .inst_mem_wr_data(wr_data_s[1]),
    .boot_mode(mode_s[1]), .boot_done(done_s[1]), .boot_err(err_s[1]), .words_copied(words_s[1])
  );

  // Boot memories: data for a read strobed in cycle t is on the bus in cycle t+latency.
  logic [DW-1:0] mem [2][64];
  logic [DW-1:0] mq  [2][4];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int s = 3; s > 0; s--) mq[k][s] <= mq[k][s-1];
      mq[k][0] <= rd_en_s[k] ? mem[k][rd_addr_s[k][5:0]] : POISON;
    end
  end
  assign rd_data_s[0] = mq[0][2];
  assign rd_data_s[1] = mq[1][0];

  // Bus monitors: log every read and write with its cycle number.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] w_addr [2][512];
  logic [DW-1:0] w_data [2][512];
  int            w_cyc  [2][512];
  int            w_n    [2] = '{0, 0};
  logic [AW-1:0] r_addr [2][512];
  int            r_cyc  [2][512];
  int            r_n    [2] = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wr_en_s[k] && w_n[k] < 512) begin
        w_addr[k][w_n[k]] <= wr_addr_s[k];
        w_data[k][w_n[k]] <= wr_data_s[k];
        w_cyc[k][w_n[k]]  <= cyc;
        w_n[k]            <= w_n[k] + 1;
      end
      if (rd_en_s[k] && r_n[k] < 512) begin
        r_addr[k][r_n[k]] <= rd_addr_s[k];
        r_cyc[k][r_n[k]]  <= cyc;
        r_n[k]            <= r_n[k] + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input int k);
    @(posedge clk);
    #1 boot_start_s[k] = 1'b1;
    @(posedge clk);
    #1 boot_start_s[k] = 1'b0;
  endtask

  task automatic check_reset_outputs(input int k, input string tag);
    check($sformatf("%s mode", tag),    64'(mode_s[k]),    64'(1));
    check($sformatf("%s done", tag),    64'(done_s[k]),    64'(0));
    check($sformatf("%s err", tag),     64'(err_s[k]),     64'(0));
    check($sformatf("%s rd_en", tag),   64'(rd_en_s[k]),   64'(0));
    check($sformatf("%s rd_addr", tag), 64'(rd_addr_s[k]), 64'(0));
    check($sformatf("%s wr_en", tag),   64'(wr_en_s[k]),   64'(0));
    check($sformatf("%s wr_addr", tag), 64'(wr_addr_s[k]), 64'(0));
    check($sformatf("%s wr_data", tag), 64'(wr_data_s[k]), 64'(0));
    check($sformatf("%s words", tag),   64'(words_s[k]),   64'(0));
  endtask

  // Reference image: header (junk above the length field), payload, trailer.
  int            img_len [2];
  bit            img_bad [2];
  logic [DW-1:0] img_pay [2][32];

  task automatic load_image(input int k, input int len, input bit bad);
    logic [DW-1:0] sum;
    logic [DW-1:0] w;
    int src;
    sum = '0;
    src = src_of(k);
    img_len[k] = len;
    img_bad[k] = bad;
    mem[k][src] = {12'($urandom), 20'(len)};
    for (int i = 0; i < len && i < 32; i++) begin
      w = $urandom;
      img_pay[k][i] = w;
      mem[k][src + 1 + i] = w;
      sum = sum + w;
    end
    if (len <= MAXW) mem[k][src + 1 + len] = bad ? sum + 32'd1 : sum;
  endtask

  // Start a boot (reset release or start pulse) and compare the whole run
  // against the reference image.
  task automatic run_copy(input int k, input bit by_reset, input bit poke, input string tag);
    int  len, exp_w, exp_r, wb, rb, lim;
    bit  exp_err;
    len     = img_len[k];
    exp_err = (len > MAXW) || (CHK && img_bad[k] && len != 0);
    exp_w   = (len > MAXW) ? 0 : len;
    exp_r   = (len > MAXW || len == 0) ? 1 : len + 1 + int'(CHK);
    wb      = w_n[k];
    rb      = r_n[k];
    if (by_reset) begin
      rst_n_s[k] = 1'b1;
    end else begin
      pulse_start(k);
      check($sformatf("%s start words", tag), 64'(words_s[k]), 64'(0));
      check($sformatf("%s start done", tag),  64'(done_s[k]),  64'(0));
      check($sformatf("%s start mode", tag),  64'(mode_s[k]),  64'(1));
    end
    if (poke) begin
      lim = 0;
      while (w_n[k] == wb && lim < 100) begin step(); lim++; end
      check($sformatf("%s poke wait", tag), 64'(lim < 100), 64'(1));
      pulse_start(k);
    end
    lim = 0;
    while (!(done_s[k] || err_s[k]) && lim < 400) begin step(); lim++; end
    check($sformatf("%s finish timeout", tag), 64'(lim < 400), 64'(1));
    repeat (3) step();
    check($sformatf("%s err", tag),    64'(err_s[k]),   64'(exp_err));
    check($sformatf("%s done", tag),   64'(done_s[k]),  64'(!exp_err));
    check($sformatf("%s mode", tag),   64'(mode_s[k]),  64'(exp_err));
    check($sformatf("%s words", tag),  64'(words_s[k]), 64'(exp_w));
    check($sformatf("%s n_writes", tag), 64'(w_n[k] - wb), 64'(exp_w));
    check($sformatf("%s n_reads", tag),  64'(r_n[k] - rb), 64'(exp_r));
    check($sformatf("%s hdr addr", tag), 64'(r_addr[k][rb]), 64'(src_of(k)));
    for (int i = 0; i < exp_w && i < 32 && (r_n[k] - rb) == exp_r; i++) begin
      check($sformatf("%s rd%0d addr", tag, i), 64'(r_addr[k][rb + 1 + i]), 64'(src_of(k) + 1 + i));
      check($sformatf("%s wr%0d addr", tag, i), 64'(w_addr[k][wb + i]), 64'(dst_of(k) + i));
      check($sformatf("%s wr%0d data", tag, i), 64'(w_data[k][wb + i]), 64'(img_pay[k][i]));
      check($sformatf("%s wr%0d cycle", tag, i), 64'(w_cyc[k][wb + i] - r_cyc[k][rb + 1 + i]),
            64'(lat_of(k) + 1));
    end
    if (CHK && exp_w > 0 && (r_n[k] - rb) == exp_r)
      check($sformatf("%s trailer addr", tag), 64'(r_addr[k][rb + exp_r - 1]),
            64'(src_of(k) + 1 + len));
  endtask

  initial begin
    int wb, lim, k, len;
    bit bad;
    rst_n_s      = '{1'b0, 1'b0};
    boot_start_s = '{1'b0, 1'b0};
    repeat (3) step();
    check_reset_outputs(0, "a reset");
    check_reset_outputs(1, "b reset");

    load_image(0, 8, 1'b0);
    load_image(1, 4, 1'b0);
    rst_n_s[1] = 1'b1;

    // A auto-starts; reset it after three writes, then let it rerun.
    wb = w_n[0];
    rst_n_s[0] = 1'b1;
    lim = 0;
    while (w_n[0] - wb < 3 && lim < 100) begin step(); lim++; end
    check("a abort wait", 64'(lim < 100), 64'(1));
    rst_n_s[0] = 1'b0;
    #1;
    check_reset_outputs(0, "a abort");
    wb = w_n[0];
    repeat (4) step();
    check("a abort no writes", 64'(w_n[0] - wb), 64'(0));
    run_copy(0, 1'b1, 1'b0, "a rerun");

    // B has no auto start: nothing happens until boot_start.
    check("b idle reads",  64'(r_n[1]),    64'(0));
    check("b idle writes", 64'(w_n[1]),    64'(0));
    check("b idle mode",   64'(mode_s[1]), 64'(1));
    check("b idle done",   64'(done_s[1]), 64'(0));
    run_copy(1, 1'b0, 1'b0, "b l4");
    load_image(1, 8, 1'b0);
    run_copy(1, 1'b0, 1'b1, "b poke");
    run_copy(1, 1'b0, 1'b0, "b rerun");

    // Length boundaries on A.
    load_image(0, 0, 1'b0);
    run_copy(0, 1'b0, 1'b0, "a len0");
    load_image(0, MAXW + 1, 1'b0);
    run_copy(0, 1'b0, 1'b0, "a lenmax+1");
    load_image(0, MAXW, 1'b0);
    run_copy(0, 1'b0, 1'b0, "a lenmax");
    load_image(0, 2, 1'b1);
    run_copy(0, 1'b0, 1'b0, "a badsum");
    load_image(1, 1, 1'b0);
    run_copy(1, 1'b0, 1'b0, "b len1");

    for (int it = 0; it < 8; it++) begin
      k   = it % 2;
      len = $urandom_range(1, MAXW);
      bad = 1'($urandom_range(0, 1));
      load_image(k, len, bad);
      run_copy(k, 1'b0, 1'b0, $sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
